// File: rtl/rv16_pkg.sv
// Shared definitions for the rv16 register file and its issue scoreboard.
// Module-level parameters default to these values and may override them.
package rv16_pkg;

  localparam int DATA_W      = 16;
  localparam int REG_DEPTH   = 16;
  localparam int REG_AW      = $clog2(REG_DEPTH);
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_AW-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG_ADDR = '0;

endpackage

// File: rtl/rv16_scoreboard.sv
// Per-register pending tracking for the rv16 issue stage.
// Produces issue-ready from RAW/WAW hazards and counts stalled issue cycles.
module rv16_scoreboard
  import rv16_pkg::*;
#(
  parameter int DEPTH    = REG_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [AW-1:0]          i_rs1_addr,
  input  logic [AW-1:0]          i_rs2_addr,
  input  logic                   i_issue_valid,
  input  logic                   i_issue_rd_en,
  input  logic [AW-1:0]          i_issue_rd_addr,
  input  logic                   i_wb_valid,
  input  logic [AW-1:0]          i_wb_addr,
  output logic                   o_issue_ready,
  output logic [DEPTH-1:0]       o_pending,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  logic [DEPTH-1:0]       r_pending;
  logic [DEPTH-1:0]       w_pending_next;
  logic [STALL_CNT_W-1:0] r_stall_count;
  logic                   w_rs1_blocked;
  logic                   w_rs2_blocked;
  logic                   w_rd_blocked;
  logic                   w_accept;

  // A same-cycle writeback releases a pending register; reads only benefit when data is forwarded.
  function automatic logic addrBlocked(input logic [DEPTH-1:0] pend,
                                       input logic [AW-1:0]    addr,
                                       input logic             wbHit);
    if (ZERO_REG && (addr == AW'(ZERO_REG_ADDR))) return 1'b0;
    return pend[addr] && !wbHit;
  endfunction

  assign w_rs1_blocked = addrBlocked(r_pending, i_rs1_addr,
                                     BYPASS && i_wb_valid && (i_wb_addr == i_rs1_addr));
  assign w_rs2_blocked = addrBlocked(r_pending, i_rs2_addr,
                                     BYPASS && i_wb_valid && (i_wb_addr == i_rs2_addr));
  assign w_rd_blocked  = addrBlocked(r_pending, i_issue_rd_addr,
                                     i_wb_valid && (i_wb_addr == i_issue_rd_addr));

  assign o_issue_ready = !(w_rs1_blocked || w_rs2_blocked || (i_issue_rd_en && w_rd_blocked));
  assign w_accept      = i_issue_valid && o_issue_ready && i_issue_rd_en;

  // Set is applied after clear so a newly issued writer keeps ownership of the register.
  always_comb begin
    w_pending_next = r_pending;
    if (i_wb_valid) w_pending_next[i_wb_addr] = 1'b0;
    if (w_accept)   w_pending_next[i_issue_rd_addr] = 1'b1;
    if (ZERO_REG)   w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending     <= '0;
      r_stall_count <= '0;
    end else begin
      r_pending <= w_pending_next;
      if (i_issue_valid && !o_issue_ready && (r_stall_count != '1))
        r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end
  end

  assign o_pending     = r_pending;
  assign o_stall_count = r_stall_count;

endmodule

// File: rtl/rv16_regfile_sb.sv
// rv16 register file: storage array, read ports with writeback forwarding,
// and the issue scoreboard that stalls decode on register hazards.
module rv16_regfile_sb
  import rv16_pkg::*;
#(
  parameter int DATA     = DATA_W,
  parameter int DEPTH    = REG_DEPTH,
  parameter int AW       = $clog2(DEPTH),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                   rv16_reg_clock,
  input  logic                   rv16_reg_reset,
  input  logic [AW-1:0]          rs1_addr_in,
  input  logic [AW-1:0]          rs2_addr_in,
  output logic [DATA-1:0]        rs1_reg_out,
  output logic [DATA-1:0]        rs2_reg_out,
  input  logic                   issue_valid_in,
  input  logic                   issue_rd_en_in,
  input  logic [AW-1:0]          issue_rd_addr_in,
  output logic                   issue_ready_out,
  input  logic                   wb_valid_in,
  input  logic [AW-1:0]          wb_addr_in,
  input  logic [DATA-1:0]        wb_data_in,
  output logic [DEPTH-1:0]       pending_out,
  output logic [STALL_CNT_W-1:0] stall_count_out
);

  logic [DATA-1:0] r_mem [DEPTH];
  logic            w_wb_write;
  logic            w_rs1_zero;
  logic            w_rs2_zero;

  assign w_wb_write = wb_valid_in && !(ZERO_REG && (wb_addr_in == AW'(ZERO_REG_ADDR)));
  assign w_rs1_zero = ZERO_REG && (rs1_addr_in == AW'(ZERO_REG_ADDR));
  assign w_rs2_zero = ZERO_REG && (rs2_addr_in == AW'(ZERO_REG_ADDR));

  always_ff @(posedge rv16_reg_clock) begin
    if (rv16_reg_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wb_write) begin
      r_mem[wb_addr_in] <= wb_data_in;
    end
  end

  // Forwarding only applies to a write that will actually land in the array.
  assign rs1_reg_out = (BYPASS && w_wb_write && (wb_addr_in == rs1_addr_in)) ? wb_data_in :
                       w_rs1_zero ? '0 : r_mem[rs1_addr_in];
  assign rs2_reg_out = (BYPASS && w_wb_write && (wb_addr_in == rs2_addr_in)) ? wb_data_in :
                       w_rs2_zero ? '0 : r_mem[rs2_addr_in];

  rv16_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk           (rv16_reg_clock),
    .i_reset         (rv16_reg_reset),
    .i_rs1_addr      (rs1_addr_in),
    .i_rs2_addr      (rs2_addr_in),
    .i_issue_valid   (issue_valid_in),
    .i_issue_rd_en   (issue_rd_en_in),
    .i_issue_rd_addr (issue_rd_addr_in),
    .i_wb_valid      (wb_valid_in),
    .i_wb_addr       (wb_addr_in),
    .o_issue_ready   (issue_ready_out),
    .o_pending       (pending_out),
    .o_stall_count   (stall_count_out)
  );

endmodule

// File: tb/tb_rv16_regfile_sb.sv
// Randomized plus directed bench for rv16_regfile_sb; a reference model feeds
// an expectation queue that a negedge monitor drains against the DUT outputs.
module tb_rv16_regfile_sb;
  import rv16_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DATA  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    rs1Addr, rs2Addr, rdAddr, wbAddr;
  logic [DATA-1:0]  rs1Data, rs2Data, wbData;
  logic             issueValid, rdEn, issueReady, wbValid;
  logic [DEPTH-1:0] pending;
  logic [15:0]      stallCount;

  typedef struct {
    logic [15:0] rs1;
    logic [15:0] rs2;
    logic        ready;
    logic [15:0] pend;
    logic [15:0] stall;
    int          cyc;
  } exp_t;

  exp_t        expQ[$];
  logic [15:0] mdlMem [DEPTH];
  bit          mdlPend [DEPTH];
  int          mdlStall;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  rv16_regfile_sb #(.DATA(DATA), .DEPTH(DEPTH), .AW(AW), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .rv16_reg_clock   (clk),
    .rv16_reg_reset   (rst),
    .rs1_addr_in      (rs1Addr),
    .rs2_addr_in      (rs2Addr),
    .rs1_reg_out      (rs1Data),
    .rs2_reg_out      (rs2Data),
    .issue_valid_in   (issueValid),
    .issue_rd_en_in   (rdEn),
    .issue_rd_addr_in (rdAddr),
    .issue_ready_out  (issueReady),
    .wb_valid_in      (wbValid),
    .wb_addr_in       (wbAddr),
    .wb_data_in       (wbData),
    .pending_out      (pending),
    .stall_count_out  (stallCount)
  );

  always #5 clk = ~clk;

  // Register 0 reads as zero; a live writeback to the same nonzero register is forwarded.
  function automatic logic [15:0] mdlRead(input logic [AW-1:0] a);
    if (wbValid && wbAddr == a && a != 0) return wbData;
    if (a == 0) return 16'h0;
    return mdlMem[a];
  endfunction

  function automatic bit mdlBlocked(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    if (!mdlPend[a]) return 1'b0;
    return !(wbValid && wbAddr == a);
  endfunction

  task automatic applyStimulus(input bit r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                               input bit iv, input bit re, input logic [AW-1:0] rd,
                               input bit wv, input logic [AW-1:0] wa, input logic [15:0] wd,
                               input bit chk);
    exp_t e;
    bit   rdy;
    @(posedge clk);
    #1;
    cyc++;
    rst = r; rs1Addr = a1; rs2Addr = a2; issueValid = iv; rdEn = re; rdAddr = rd;
    wbValid = wv; wbAddr = wa; wbData = wd;
    rdy = !(mdlBlocked(a1) || mdlBlocked(a2) || (re && mdlBlocked(rd)));
    e.rs1 = mdlRead(a1);
    e.rs2 = mdlRead(a2);
    e.ready = rdy;
    for (int i = 0; i < DEPTH; i++) e.pend[i] = mdlPend[i];
    e.stall = 16'(mdlStall);
    e.cyc = cyc;
    if (chk) expQ.push_back(e);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) begin
        mdlMem[i] = 16'h0;
        mdlPend[i] = 1'b0;
      end
      mdlStall = 0;
    end else begin
      if (wv && wa != 0) mdlMem[wa] = wd;
      if (wv) mdlPend[wa] = 1'b0;
      if (iv && rdy && re && rd != 0) mdlPend[rd] = 1'b1;
      if (iv && !rdy && mdlStall < 65535) mdlStall++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want,
                             input int c);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("rs1", rs1Data, e.rs1, e.cyc);
      checkOutput("rs2", rs2Data, e.rs2, e.cyc);
      checkOutput("ready", {15'h0, issueReady}, {15'h0, e.ready}, e.cyc);
      checkOutput("pending", pending, e.pend, e.cyc);
      checkOutput("stall", stallCount, e.stall, e.cyc);
    end
  end

  initial begin
    rst = 1'b1; rs1Addr = '0; rs2Addr = '0; issueValid = 1'b0; rdEn = 1'b0; rdAddr = '0;
    wbValid = 1'b0; wbAddr = '0; wbData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdlMem[i] = 16'h0;
      mdlPend[i] = 1'b0;
    end
    mdlStall = 0;

    // Reset twice; writeback and issue presented during reset must be ignored.
    applyStimulus(1, 0, 0, 1, 1, 4, 1, 2, 16'hAAAA, 0);
    applyStimulus(1, 2, 4, 1, 1, 4, 0, 2, 16'hAAAA, 1);
    for (int a = 0; a < DEPTH; a++)
      applyStimulus(0, 4'(a), 4'(DEPTH - 1 - a), 0, 0, 0, 0, 0, 16'h0, 1);

    applyStimulus(0, 5, 0, 0, 0, 0, 1, 5, 16'hBEEF, 1);
    applyStimulus(0, 5, 5, 0, 0, 0, 0, 0, 16'h0, 1);
    applyStimulus(0, 5, 0, 0, 0, 0, 0, 5, 16'h1111, 1);

    applyStimulus(0, 0, 0, 1, 1, 0, 1, 0, 16'h1234, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);

    applyStimulus(0, 0, 0, 1, 1, 3, 0, 0, 16'h0, 1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 3, 1, 0, 0, 0, 0, 16'h0, 1);
    applyStimulus(0, 0, 3, 1, 0, 0, 1, 3, 16'hC0DE, 1);
    applyStimulus(0, 0, 3, 0, 0, 0, 0, 0, 16'h0, 1);

    applyStimulus(0, 0, 0, 1, 1, 7, 1, 7, 16'h7777, 1);
    applyStimulus(0, 7, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    applyStimulus(0, 7, 0, 1, 1, 7, 0, 0, 16'h0, 1);
    applyStimulus(0, 7, 0, 0, 0, 0, 1, 7, 16'h4242, 1);
    applyStimulus(0, 7, 0, 0, 0, 0, 0, 0, 16'h0, 1);

    // Narrow address range keeps hazards, bypass hits and set/clear collisions frequent.
    for (int k = 0; k < 500; k++)
      applyStimulus(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), 4'($urandom_range(0, 7)),
                    1'($urandom), 4'($urandom_range(0, 7)), 16'($urandom), 1);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, 0, 0, 16'h0, 1);
    for (int k = 0; k < 70000; k++)
      applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 16'h0, (k < 3) || (k >= 69995));
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 1);

    @(posedge clk);
    #1;
    rst = 1'b0; issueValid = 1'b0; wbValid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain leftover=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv16_regfile_sb.md
# rv16_regfile_sb

Parametrised register file with integrated scoreboard for the rv16 core pipeline. It provides two combinational read ports and one writeback port with write enable and qualified write-to-read bypass. A per-register pending bit is set at issue and cleared at writeback, and an issue-ready signal stalls decode on RAW/WAW hazards. It sits between decode/issue and the writeback stage and supersedes the fixed 16x16 register file.

## Interface
- DATA, 16, register width in bits
- DEPTH, 16, number of architectural registers (power of two, 2..64)
- AW, $clog2(DEPTH), register address width
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/pending

- rv16_reg_clock  in  1  sole clock, rising edge
- rv16_reg_reset  in  1  synchronous, active-high reset
- rs1_addr_in  in  AW  read port 1 address
- rs2_addr_in  in  AW  read port 2 address
- rs1_reg_out  out  DATA  read port 1 data
- rs2_reg_out  out  DATA  read port 2 data
- issue_valid_in  in  1  decode presents an instruction this cycle
- issue_rd_en_in  in  1  issuing instruction writes a destination
- issue_rd_addr_in  in  AW  destination of issuing instruction
- issue_ready_out  out  1  no hazard; issue accepted when valid & ready
- wb_valid_in  in  1  writeback strobe
- wb_addr_in  in  AW  writeback destination
- wb_data_in  in  DATA  writeback data
- pending_out  out  DEPTH  per-register pending bits
- stall_count_out  out  16  saturating count of stalled issue cycles

## Operation
- Write: on a clock edge with wb_valid_in=1 and not reset, reg[wb_addr_in] <= wb_data_in; suppressed when ZERO_REG=1 and wb_addr_in=0.
- Read: rsN_reg_out = wb_data_in when BYPASS=1, wb_valid_in=1, wb_addr_in=rsN_addr_in, and the write is not suppressed; 0 when ZERO_REG=1 and address 0; otherwise reg[rsN_addr_in]. Bypass is never taken without wb_valid_in.
- Hazard: an address is blocked if pending and not cleared by a same-cycle writeback to it. With BYPASS=0, a same-cycle writeback does not unblock rs1/rs2.
- issue_ready_out = !(rs1 blocked | rs2 blocked | (issue_rd_en_in & rd blocked)). Address 0 is never blocked when ZERO_REG=1. issue_ready_out is independent of issue_valid_in.
- Accept = issue_valid_in & issue_ready_out & issue_rd_en_in. On accept, pending[issue_rd_addr_in] <= 1, except address 0 when ZERO_REG=1.
- Writeback clears pending[wb_addr_in]. A writeback to a non-pending register writes data and leaves pending at 0.
- Simultaneous set and clear of the same index: set wins, because the new instruction owns the register.
- stall_count_out increments each cycle issue_valid_in & !issue_ready_out, and saturates at 16'hFFFF.

## Timing
- Reads and issue_ready_out are combinational, with zero latency.
- Written data is visible on read ports the next cycle, or the same cycle via bypass.
- Pending set/clear is visible on pending_out the cycle after the edge.
- Reset (one cycle suffices): all DEPTH registers = 0, pending_out = 0, stall_count_out = 0. The loop is bounded by DEPTH. issue_ready_out = 1 follows, because nothing is pending.
- Writeback and issue in a reset cycle are ignored. Reset mid-operation discards all pending state, and later writebacks to those registers just write data.

## Structure
- Shared package rv16_pkg holds:
  - DATA width default
  - reg_addr_t typedef
  - ZERO_REG_ADDR constant
  - STALL_CNT_W = 16
- Sub-module rv16_scoreboard contains:
  - pending bits
  - set/clear priority
  - blocked/ready logic
  - stall counter
- The top level holds the storage array, bypass muxes, and the scoreboard instance.

## Test plan
- Reset, then read all addresses -> every rsN_reg_out = 0, pending_out = 0, issue_ready_out = 1, stall_count_out = 0.
- wb r5 = 16'hBEEF, with rs1 = 5 in the same cycle -> rs1_reg_out = 16'hBEEF (BYPASS=1). The next cycle, rs1 = 5 also reads 16'hBEEF. Repeat with wb_valid_in = 0 and wb_addr_in = 5 -> no bypass, old value is returned.
- wb r0 = 16'h1234 and issue with rd = 0 -> r0 reads 0, pending_out[0] stays 0.
- Issue rd = 3, then issue with rs2 = 3 for 4 cycles -> issue_ready_out = 0 and stall_count_out = 4. A wb to r3 in the 5th cycle -> ready = 1 that cycle, rs2_reg_out = wb data, and pending_out[3] = 0 the next cycle.
- Accept an issue rd = 7 in the same cycle as wb r7 -> pending_out[7] = 1 afterwards. Assert reset while r7 is pending -> pending_out = 0 the next cycle.
- Hold issue_valid_in with a blocked rs1 for 70000 cycles -> stall_count_out = 16'hFFFF.
